// File: rtl/fsic_io_serdes_pkg.sv
// Shared definitions for the FSIC IO SerDes transmitter and its receiver peer.
package fsic_io_serdes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2
   } serdes_state_e;

   localparam int FSIC_CLK_RATIO   = 4;
   localparam int FSIC_LEAD_CYCLES = 2;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsic_io_serdes_tx_fifo.sv
// Small synchronous word FIFO with flush; depth must be a power of two.
module fsic_io_serdes_tx_fifo
   import fsic_io_serdes_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// Transmit serializer: buffers parallel words and emits them LSB-first as an
// unframed, gap-free bit stream preceded by a short run of lead-in zeros.
//
// state    | meaning
// ST_IDLE  | pin low, waiting for txen with a buffered word
// ST_LEAD  | lead-in zeros, lead counter 0..pLEAD_CYCLES-1
// ST_SHIFT | shifting words (or zero fillers on underrun), one bit per clock
module fsic_io_serdes_tx
   import fsic_io_serdes_pkg::*;
#(
   parameter int pCLK_RATIO    = FSIC_CLK_RATIO,
   parameter int pTxFIFO_DEPTH = 2,
   parameter int pLEAD_CYCLES  = FSIC_LEAD_CYCLES
) (
   input  logic                  ioclk,
   input  logic                  axis_rst,
   input  logic                  txen,
   input  logic [pCLK_RATIO-1:0] txdata_in,
   input  logic                  txdata_in_valid,
   output logic                  txdata_in_ready,
   output logic                  Serial_Data_out,
   output logic                  tx_active,
   output logic                  tx_word_start,
   output logic                  tx_underrun
);

   localparam int PW = cnt_width(pCLK_RATIO);
   localparam int LW = cnt_width(pLEAD_CYCLES);
   localparam logic [PW-1:0] PHASE_LAST = PW'(pCLK_RATIO - 1);
   localparam logic [LW-1:0] LEAD_LAST  = LW'(pLEAD_CYCLES - 1);

   serdes_state_e         state_q, state_d;
   logic [LW-1:0]         lead_q, lead_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [pCLK_RATIO-1:0] shreg_q, shreg_d;
   logic                  sdo_q, sdo_d;
   logic                  wstart_q, wstart_d;
   logic                  undr_q, undr_d;
   logic                  load_word;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [pCLK_RATIO-1:0] fifo_rdata;

   assign txdata_in_ready = txen && !fifo_full && !axis_rst;
   assign fifo_push       = txdata_in_valid && txdata_in_ready;

   fsic_io_serdes_tx_fifo #(
      .WIDTH (pCLK_RATIO),
      .DEPTH (pTxFIFO_DEPTH)
   ) u_fifo (
      .clk_i   (ioclk),
      .rst_i   (axis_rst),
      .flush_i (!txen),
      .push_i  (fifo_push),
      .wdata_i (txdata_in),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      lead_d    = lead_q;
      phase_d   = phase_q;
      shreg_d   = shreg_q;
      sdo_d     = 1'b0;
      wstart_d  = 1'b0;
      undr_d    = undr_q;
      load_word = 1'b0;
      fifo_pop  = 1'b0;

      if (!txen) begin
         state_d = ST_IDLE;
         lead_d  = '0;
         phase_d = '0;
         shreg_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               lead_d  = '0;
               phase_d = '0;
               if (!fifo_empty) state_d = ST_LEAD;
            end
            ST_LEAD: begin
               if (lead_q == LEAD_LAST) begin
                  state_d   = ST_SHIFT;
                  lead_d    = '0;
                  load_word = 1'b1;
               end else begin
                  lead_d = lead_q + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (phase_q == PHASE_LAST) begin
                  load_word = 1'b1;
               end else begin
                  phase_d = phase_q + 1'b1;
                  sdo_d   = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // The receiver has no framing, so an empty FIFO gets a zero filler
         // word rather than a pause in the stream.
         if (load_word) begin
            phase_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sdo_d    = fifo_rdata[0];
               shreg_d  = fifo_rdata >> 1;
               wstart_d = 1'b1;
            end else begin
               sdo_d   = 1'b0;
               shreg_d = '0;
               undr_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ioclk) begin
      if (axis_rst) begin
         state_q  <= ST_IDLE;
         lead_q   <= '0;
         phase_q  <= '0;
         shreg_q  <= '0;
         sdo_q    <= 1'b0;
         wstart_q <= 1'b0;
         undr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lead_q   <= lead_d;
         phase_q  <= phase_d;
         shreg_q  <= shreg_d;
         sdo_q    <= sdo_d;
         wstart_q <= wstart_d;
         undr_q   <= undr_d;
      end
   end

   assign Serial_Data_out = sdo_q;
   assign tx_active       = (state_q == ST_LEAD) || (state_q == ST_SHIFT);
   assign tx_word_start   = wstart_q;
   assign tx_underrun     = undr_q;

endmodule
